leaf_stream_tx: RTL and testbench
=================================

# leaf_stream_tx

Credit-based BFT transmitter for one leaf output port. It accepts 32-bit words from an HLS producer over an ap_vld/ap_ack handshake and emits one 49-bit data packet per word onto the leaf's BFT output link. It throttles the producer against a credit count that the destination leaf's receive buffer replenishes through credit packets arriving on the BFT input link.

## Interface
Parameters:
- PACKET_BITS, 49, BFT packet width
- PAYLOAD_BITS, 32, user word width
- NUM_LEAF_BITS, 3, leaf address width
- NUM_PORT_BITS, 4, port address width
- NUM_ADDR_BITS, 7, sequence/buffer address width
- MY_LEAF, 0, own leaf address; credit packets must match it
- MY_PORT, 2, own port address; credit packets must match it
- MAX_CREDIT, 128, receiver buffer depth (2^NUM_ADDR_BITS)

Ports:
- clk  in  1  sole clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ap_start  in  1  leave IDLE; samples dst_leaf/dst_port
- dst_leaf  in  3  destination leaf
- dst_port  in  4  destination port
- din_leaf_bft2interface  in  49  incoming BFT packets; credit packets only are consumed
- dout_leaf_interface2bft  out  49  outgoing BFT packets, registered
- din_leaf_user2interface  in  32  producer data
- vld_user2interface  in  1  producer valid; held high until acked
- ack_interface2user  out  1  word accepted this cycle; combinational
- credit_count  out  8  current credits, 0..MAX_CREDIT

## Operation
- Packet format, all directions: [48] valid, [47:45] dst leaf, [44:41] dst port, [40:39] type (00 data, 01 credit), [38:32] seq, [31:0] payload.
- States:
  - IDLE: ack=0. ap_start=1 latches dst_leaf and dst_port, then goes to RUN.
  - RUN: credit_next==0 after an accept goes to WAIT_CREDIT.
  - WAIT_CREDIT: ack=0. credit_next>0 goes to RUN.
  - No path back to IDLE except reset.
- ack_interface2user = (state==RUN) && vld_user2interface && (credit_count!=0).
- On accept:
  - next cycle dout = {1, dst_leaf_q, dst_port_q, 2'b00, seq, din_leaf_user2interface}.
  - seq increments modulo 128 (127 wraps to 0).
  - credit decrements by 1.
- No accept: next cycle dout = 49'd0.
- Credit packet: din[48]=1, type=01, din[47:45]==MY_LEAF, din[44:41]==MY_PORT. The increment is din[7:0]. Any other din packet is ignored.
- Credit update in one cycle: credit_next = min(MAX_CREDIT, credit_count − accept + inc). An accept and a credit packet in the same cycle are both applied. The sum saturates at MAX_CREDIT and never wraps.
- Credit packets are honoured in every state, including IDLE.
- ap_start outside IDLE is ignored, and destination changes are ignored.

## Timing
- Reset values:
  - dout_leaf_interface2bft=0, ack=0 (state IDLE).
  - credit_count=MAX_CREDIT, seq=0, dst_leaf_q=0, dst_port_q=0.
- Reset assertion mid-packet clears dout immediately (asynchronous). A word being acked in that cycle is lost, and the producer must re-present it.
- Latency: accept in cycle N gives a valid packet on dout in cycle N+1. Throughput is one word per cycle while credits are nonzero.
- Credit packet at the din edge in cycle N: credit_count updates at N+1, and ack can assert in N+1.
- ap_start in cycle N puts state=RUN at N+1. The first possible ack is in N+1.
- ack is combinational from vld and registered state. There is no ack→vld loop because the producer does not gate vld on ack.

## Test plan
- Reset then idle:
  - stimulus: hold reset_n=0, then release with vld=1 and no ap_start for 10 cycles.
  - required: ack=0, dout=0, credit_count=128.
- Streaming:
  - stimulus: ap_start with dst_leaf=5, dst_port=3; stream words 0xA0000000..+9 back-to-back.
  - required: 10 packets on consecutive cycles, each one cycle after its ack. Bits [47:41]={5,3}, type=00, seq 0..9, payloads in order. credit_count=118.
- Credit exhaustion:
  - stimulus: stream 128 words, then inject a credit packet to MY_LEAF/MY_PORT with payload 4.
  - required: ack drops after the 128th word and state=WAIT_CREDIT. Exactly 4 more words go out, and the 129th word carries seq=0 (wrap).
- Simultaneous accept and credit:
  - stimulus: at credit_count=1, assert vld together with a credit packet of inc=3.
  - required: credit_count becomes 3 and state stays RUN.
- Saturation and filtering:
  - stimulus: at credit_count=128, inject a credit of 50; then a credit packet for port 1; then a data-type packet to MY_PORT.
  - required: credit_count stays 128 throughout.
- Async reset mid-stream:
  - stimulus: drop reset_n between edges during streaming.
  - required: dout=0 and ack=0 immediately. After release, state=IDLE, seq restarts at 0, and credits=128.

Source files
------------

// File: rtl/leaf_stream_tx.sv
// leaf_stream_tx: credit-throttled BFT transmitter turning ap_vld/ap_ack user words into data packets.
module leaf_stream_tx #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 3,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int MY_LEAF       = 0,
  parameter int MY_PORT       = 2,
  parameter int MAX_CREDIT    = 128
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ap_start,
  input  logic [NUM_LEAF_BITS-1:0] dst_leaf,
  input  logic [NUM_PORT_BITS-1:0] dst_port,
  input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic                     vld_user2interface,
  output logic                     ack_interface2user,
  output logic [NUM_ADDR_BITS:0]   credit_count
);
  localparam int CW      = NUM_ADDR_BITS + 1;
  localparam int SW      = CW + 2;
  localparam int TYPE_LO = PAYLOAD_BITS + NUM_ADDR_BITS;
  localparam int PORT_LO = TYPE_LO + 2;
  localparam int LEAF_LO = PORT_LO + NUM_PORT_BITS;
  typedef enum logic [1:0] {IDLE, RUN, WAIT_CREDIT} state_t;
  state_t state, state_next;
  logic [NUM_LEAF_BITS-1:0] leaf_q;
  logic [NUM_PORT_BITS-1:0] port_q;
  logic [NUM_ADDR_BITS-1:0] seq;
  logic                     credit_pkt;
  logic [SW-1:0]            credit_sum;
  logic [CW-1:0]            credit_next;
  logic                     unused_din;
  assign unused_din = ^din_leaf_bft2interface[TYPE_LO-1:8];
  assign credit_pkt = din_leaf_bft2interface[PACKET_BITS-1]
                   && din_leaf_bft2interface[PORT_LO-1:TYPE_LO] == 2'b01
                   && din_leaf_bft2interface[LEAF_LO+NUM_LEAF_BITS-1:LEAF_LO] == NUM_LEAF_BITS'(MY_LEAF)
                   && din_leaf_bft2interface[LEAF_LO-1:PORT_LO] == NUM_PORT_BITS'(MY_PORT);
  assign ack_interface2user = state == RUN && vld_user2interface && credit_count != '0;
  // accept only fires with credit_count>0, so the subtraction never underflows
  assign credit_sum  = SW'(credit_count) + (credit_pkt ? SW'(din_leaf_bft2interface[7:0]) : '0)
                     - SW'(ack_interface2user);
  assign credit_next = credit_sum > SW'(MAX_CREDIT) ? CW'(MAX_CREDIT) : credit_sum[CW-1:0];
  always_comb begin
    state_next = state;
    state_next = state == IDLE ? (ap_start ? RUN : IDLE)
               : (credit_next == '0 ? WAIT_CREDIT : RUN);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_leaf_interface2bft <= '0;
      credit_count            <= CW'(MAX_CREDIT);
      seq                     <= '0;
      leaf_q                  <= '0;
      port_q                  <= '0;
    end else begin
      credit_count            <= credit_next;
      dout_leaf_interface2bft <= ack_interface2user
        ? {1'b1, leaf_q, port_q, 2'b00, seq, din_leaf_user2interface} : '0;
      if (ack_interface2user) seq <= seq + 1'b1;
      if (state == IDLE && ap_start) begin
        leaf_q <= dst_leaf;
        port_q <= dst_port;
      end
    end
  end
endmodule

// File: tb/tb_leaf_stream_tx.sv
// tb_leaf_stream_tx: directed stimulus with a per-cycle reference model check plus literal pins.
module tb_leaf_stream_tx;
  logic        clk = 0, reset_n = 0, ap_start = 0, vld = 0;
  logic [2:0]  dst_leaf = 0;
  logic [3:0]  dst_port = 0;
  logic [48:0] din_bft = 0, dout;
  logic [31:0] din_user = 0;
  logic        ack;
  logic [7:0]  credit_count;
  int n_checks = 0, n_fail = 0;
  bit          m_run = 0;
  int          m_credit = 128, m_seq = 0, m_acc = 0;
  logic [2:0]  m_leaf = 0;
  logic [3:0]  m_port = 0;
  logic [48:0] m_dout = 0;
  bit          a;
  int          inc, nc, base;
  bit          first;
  always #5 clk = ~clk;
  leaf_stream_tx dut (
    .clk(clk), .reset_n(reset_n), .ap_start(ap_start), .dst_leaf(dst_leaf), .dst_port(dst_port),
    .din_leaf_bft2interface(din_bft), .dout_leaf_interface2bft(dout),
    .din_leaf_user2interface(din_user), .vld_user2interface(vld),
    .ack_interface2user(ack), .credit_count(credit_count)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit m_ack();
    return m_run && vld && m_credit != 0;
  endfunction
  function automatic logic [48:0] cpkt(input logic [2:0] l, input logic [3:0] p, input logic [1:0] t, input logic [7:0] i);
    return {1'b1, l, p, t, 7'd0, 24'd0, i};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // reference: credits are a saturating integer, the producer may send whenever started and credits remain
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 0; m_credit = 128; m_seq = 0; m_leaf = 0; m_port = 0; m_dout = 0;
    end else begin
      a = m_ack();
      inc = (din_bft[48] && din_bft[40:39] == 2'b01 && din_bft[47:45] == 3'd0 && din_bft[44:41] == 4'd2)
          ? int'(din_bft[7:0]) : 0;
      m_dout = a ? {1'b1, m_leaf, m_port, 2'b00, 7'(m_seq), din_user} : 49'd0;
      nc = m_credit - int'(a) + inc;
      m_credit = nc > 128 ? 128 : nc;
      if (a) begin m_seq = (m_seq + 1) % 128; m_acc++; end
      if (!m_run && ap_start) begin m_run = 1; m_leaf = dst_leaf; m_port = dst_port; end
    end
  end
  always @(negedge clk) begin
    chk("ack", 64'(ack), 64'(m_ack()));
    chk("dout", 64'(dout), 64'(m_dout));
    chk("credit", 64'(credit_count), 64'(m_credit));
  end
  initial begin
    repeat (3) tick();
    vld = 1; din_user = 32'hDEADBEEF;
    reset_n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ack", 64'(ack), 64'd0);
      chk("idle_dout", 64'(dout), 64'd0);
      chk("idle_credit", 64'(credit_count), 64'd128);
    end
    vld = 0; dst_leaf = 5; dst_port = 3; ap_start = 1;
    tick();
    ap_start = 0; dst_leaf = 7; dst_port = 0;
    for (int i = 0; i < 10; i++) begin
      vld = 1; din_user = 32'hA0000000 + i;
      tick();
      if (i == 0) chk("first_pkt", 64'(dout), 64'({1'b1, 3'd5, 4'd3, 2'b00, 7'd0, 32'hA0000000}));
      if (i == 9) chk("last_pkt", 64'(dout), 64'({1'b1, 3'd5, 4'd3, 2'b00, 7'd9, 32'hA0000009}));
    end
    vld = 0;
    tick();
    chk("credit118", 64'(credit_count), 64'd118);
    vld = 1; din_user = 32'hC0000000;
    tick(); tick();
    #3 reset_n = 0;
    #1;
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    tick();
    #4 reset_n = 1;
    tick();
    chk("rst_credit", 64'(credit_count), 64'd128);
    chk("rst_idle_ack", 64'(ack), 64'd0);
    vld = 0; dst_leaf = 1; dst_port = 2; ap_start = 1;
    tick();
    ap_start = 0;
    base = m_acc;
    vld = 1; din_user = 32'hB0000000;
    tick();
    chk("seq_restart", 64'(dout), 64'({1'b1, 3'd1, 4'd2, 2'b00, 7'd0, 32'hB0000000}));
    for (int i = 1; i < 130; i++) begin
      din_user = 32'hB0000000 + (m_acc - base);
      tick();
    end
    chk("acks128", 64'(m_acc - base), 64'd128);
    chk("exhaust_ack", 64'(ack), 64'd0);
    chk("exhaust_credit", 64'(credit_count), 64'd0);
    din_bft = cpkt(3'd0, 4'd2, 2'b01, 8'd4);
    tick();
    din_bft = 0;
    chk("refill_credit", 64'(credit_count), 64'd4);
    chk("refill_ack", 64'(ack), 64'd1);
    first = 1;
    for (int i = 0; i < 10; i++) begin
      din_user = 32'hB0000000 + (m_acc - base);
      tick();
      if (first && dout[48]) begin
        chk("wrap_seq", 64'(dout[38:32]), 64'd0);
        first = 0;
      end
    end
    chk("acks132", 64'(m_acc - base), 64'd132);
    vld = 0; din_bft = cpkt(3'd0, 4'd2, 2'b01, 8'd1);
    tick();
    din_bft = 0;
    chk("credit1", 64'(credit_count), 64'd1);
    vld = 1; din_bft = cpkt(3'd0, 4'd2, 2'b01, 8'd3);
    tick();
    din_bft = 0;
    chk("simul_credit", 64'(credit_count), 64'd3);
    chk("simul_run", 64'(ack), 64'd1);
    vld = 0;
    din_bft = cpkt(3'd0, 4'd1, 2'b01, 8'd9); tick();
    din_bft = cpkt(3'd1, 4'd2, 2'b01, 8'd9); tick();
    din_bft = cpkt(3'd0, 4'd2, 2'b00, 8'd9); tick();
    din_bft = {1'b0, 3'd0, 4'd2, 2'b01, 7'd0, 32'd9}; tick();
    din_bft = 0;
    chk("filter_credit", 64'(credit_count), 64'd3);
    din_bft = cpkt(3'd0, 4'd2, 2'b01, 8'd255); tick();
    chk("sat_credit", 64'(credit_count), 64'd128);
    din_bft = cpkt(3'd0, 4'd2, 2'b01, 8'd50); tick();
    chk("sat50_credit", 64'(credit_count), 64'd128);
    din_bft = cpkt(3'd0, 4'd1, 2'b01, 8'd50); tick();
    din_bft = cpkt(3'd0, 4'd2, 2'b00, 8'd50); tick();
    din_bft = 0;
    tick();
    chk("sat_final", 64'(credit_count), 64'd128);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
